// File: rtl/pipeline_hazard_controller.sv
// Combined hazard unit for the 5-stage pipeline: ALU forwarding selects, load-use stalling,
// taken-branch flushing, data-memory freeze and saturating stall/flush event counters.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W         = 5,
  parameter int LOAD_STALL_CYCLES  = 1,
  parameter int BRANCH_FLUSH_DEPTH = 3,
  parameter int CNT_W              = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_regwrite_i,
  input  logic                  mem_access_i,
  input  logic                  dmem_ready_i,
  input  logic                  branch_taken_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_regwrite_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  pipe_advance_o,
  output logic                  id_ex_bubble_o,
  output logic [2:0]            flush_o,
  output logic [1:0]            forward_a_o,
  output logic [1:0]            forward_b_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_events_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL    = 2'b01,
    MEM_WAIT = 2'b10,
    ILLEGAL  = 2'b11
  } state_e;

  localparam int FLUSH_INT = (1 << BRANCH_FLUSH_DEPTH) - 1;
  localparam logic [2:0] FLUSH_MASK = FLUSH_INT[2:0];
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stallCycles_q, stallCycles_d;
  logic [CNT_W-1:0] flushEvents_q, flushEvents_d;

  logic       luh, fz, stallActive, stallInc, flushInc;
  logic       pcWr, ifIdWr, advance, bubble;
  logic [2:0] flushVec;
  logic [1:0] fwdA, fwdB;

  // EX/MEM result is newer than MEM/WB, so it takes precedence; r0 is never forwarded.
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (mem_regwrite_i && mem_rd_i != '0 && mem_rd_i == ex_rs_i)
      fwdA = 2'b10;
    else if (wb_regwrite_i && wb_rd_i != '0 && wb_rd_i == ex_rs_i)
      fwdA = 2'b01;
    if (mem_regwrite_i && mem_rd_i != '0 && mem_rd_i == ex_rt_i)
      fwdB = 2'b10;
    else if (wb_regwrite_i && wb_rd_i != '0 && wb_rd_i == ex_rt_i)
      fwdB = 2'b01;
  end

  assign luh = ex_memread_i && ex_rd_i != '0 &&
               (ex_rd_i == id_rs_i || (id_uses_rt_i && ex_rd_i == id_rt_i));
  assign fz  = mem_access_i && !dmem_ready_i;

  // Leaving a freeze resumes the interrupted stall directly in that same cycle.
  assign stallActive = (state_q == STALL) || (state_q == MEM_WAIT && cnt_q != 3'd0);

  always_comb begin
    state_d  = RUN;
    cnt_d    = cnt_q;
    stallInc = 1'b0;
    flushInc = 1'b0;
    pcWr     = 1'b1;
    ifIdWr   = 1'b1;
    advance  = 1'b1;
    bubble   = 1'b0;
    flushVec = 3'b000;
    if (fz) begin
      pcWr    = 1'b0;
      ifIdWr  = 1'b0;
      advance = 1'b0;
      state_d = MEM_WAIT;
    end else if (branch_taken_i) begin
      flushVec = FLUSH_MASK;
      flushInc = 1'b1;
      cnt_d    = 3'd0;
      state_d  = RUN;
    end else if (stallActive) begin
      pcWr     = 1'b0;
      ifIdWr   = 1'b0;
      bubble   = 1'b1;
      stallInc = 1'b1;
      cnt_d    = cnt_q - 3'd1;
      state_d  = (cnt_q == 3'd1) ? RUN : STALL;
    end else if (luh) begin
      pcWr     = 1'b0;
      ifIdWr   = 1'b0;
      bubble   = 1'b1;
      stallInc = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        cnt_d   = STALL_RELOAD;
        state_d = STALL;
      end else begin
        cnt_d   = 3'd0;
        state_d = RUN;
      end
    end else begin
      cnt_d   = 3'd0;
      state_d = RUN;
    end
  end

  always_comb begin
    stallCycles_d = stallCycles_q;
    flushEvents_d = flushEvents_q;
    if (stallInc && stallCycles_q != '1)
      stallCycles_d = stallCycles_q + CNT_ONE;
    if (flushInc && flushEvents_q != '1)
      flushEvents_d = flushEvents_q + CNT_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      stallCycles_q <= '0;
      flushEvents_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stallCycles_q <= stallCycles_d;
      flushEvents_q <= flushEvents_d;
    end
  end

  // While reset is held every control output is forced inactive, whatever the inputs say.
  assign pc_write_o     = rst_ni & pcWr;
  assign if_id_write_o  = rst_ni & ifIdWr;
  assign pipe_advance_o = rst_ni & advance;
  assign id_ex_bubble_o = rst_ni & bubble;
  assign flush_o        = rst_ni ? flushVec : 3'b000;
  assign forward_a_o    = rst_ni ? fwdA : 2'b00;
  assign forward_b_o    = rst_ni ? fwdB : 2'b00;
  assign state_o        = state_q;
  assign stall_cycles_o = stallCycles_q;
  assign flush_events_o = flushEvents_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; three instances cover load latency 1 and 3,
// flush depth 3 and 1, and a 4-bit counter for saturation.
module tb_pipeline_hazard_controller;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] idRs, idRt, exRs, exRt, exRd, memRd, wbRd;
  logic          idUsesRt, exMemread, memRegwrite, memAccess, dmemReady, branchTaken, wbRegwrite;

  logic        pcA, ifidA, advA, bubA, pcB, ifidB, advB, bubB, pcC, ifidC, advC, bubC;
  logic [2:0]  flA, flB, flC;
  logic [1:0]  faA, fbA, faB, fbB, faC, fbC, stA, stB, stC;
  logic [15:0] scA, feA, scB, feB;
  logic [3:0]  scC, feC;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.REG_ADDR_W(AW), .LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_DEPTH(3), .CNT_W(16)) dutA (
    .clk_i(clk), .rst_ni(rst_n), .id_rs_i(idRs), .id_rt_i(idRt), .id_uses_rt_i(idUsesRt),
    .ex_rs_i(exRs), .ex_rt_i(exRt), .ex_rd_i(exRd), .ex_memread_i(exMemread),
    .mem_rd_i(memRd), .mem_regwrite_i(memRegwrite), .mem_access_i(memAccess), .dmem_ready_i(dmemReady),
    .branch_taken_i(branchTaken), .wb_rd_i(wbRd), .wb_regwrite_i(wbRegwrite),
    .pc_write_o(pcA), .if_id_write_o(ifidA), .pipe_advance_o(advA), .id_ex_bubble_o(bubA),
    .flush_o(flA), .forward_a_o(faA), .forward_b_o(fbA), .state_o(stA),
    .stall_cycles_o(scA), .flush_events_o(feA));

  pipeline_hazard_controller #(.REG_ADDR_W(AW), .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_DEPTH(3), .CNT_W(16)) dutB (
    .clk_i(clk), .rst_ni(rst_n), .id_rs_i(idRs), .id_rt_i(idRt), .id_uses_rt_i(idUsesRt),
    .ex_rs_i(exRs), .ex_rt_i(exRt), .ex_rd_i(exRd), .ex_memread_i(exMemread),
    .mem_rd_i(memRd), .mem_regwrite_i(memRegwrite), .mem_access_i(memAccess), .dmem_ready_i(dmemReady),
    .branch_taken_i(branchTaken), .wb_rd_i(wbRd), .wb_regwrite_i(wbRegwrite),
    .pc_write_o(pcB), .if_id_write_o(ifidB), .pipe_advance_o(advB), .id_ex_bubble_o(bubB),
    .flush_o(flB), .forward_a_o(faB), .forward_b_o(fbB), .state_o(stB),
    .stall_cycles_o(scB), .flush_events_o(feB));

  pipeline_hazard_controller #(.REG_ADDR_W(AW), .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_DEPTH(1), .CNT_W(4)) dutC (
    .clk_i(clk), .rst_ni(rst_n), .id_rs_i(idRs), .id_rt_i(idRt), .id_uses_rt_i(idUsesRt),
    .ex_rs_i(exRs), .ex_rt_i(exRt), .ex_rd_i(exRd), .ex_memread_i(exMemread),
    .mem_rd_i(memRd), .mem_regwrite_i(memRegwrite), .mem_access_i(memAccess), .dmem_ready_i(dmemReady),
    .branch_taken_i(branchTaken), .wb_rd_i(wbRd), .wb_regwrite_i(wbRegwrite),
    .pc_write_o(pcC), .if_id_write_o(ifidC), .pipe_advance_o(advC), .id_ex_bubble_o(bubC),
    .flush_o(flC), .forward_a_o(faC), .forward_b_o(fbC), .state_o(stC),
    .stall_cycles_o(scC), .flush_events_o(feC));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lu: load in EX writing r5 read by ID; br: taken branch; fr: data memory not ready.
  task automatic applyStimulus(input logic lu, input logic br, input logic fr);
    exMemread   = lu;
    exRd        = lu ? 5'd5 : 5'd0;
    idRs        = lu ? 5'd5 : 5'd0;
    branchTaken = br;
    memAccess   = fr;
    dmemReady   = !fr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idRs = '0; idRt = '0; exRs = 5'd3; exRt = '0; exRd = '0; memRd = 5'd3; wbRd = '0;
    idUsesRt = 1'b0; exMemread = 1'b0; memRegwrite = 1'b1; memAccess = 1'b0;
    dmemReady = 1'b1; branchTaken = 1'b0; wbRegwrite = 1'b0;
    #2;
    checkOutput("rst_pc_write", 32'(pcA), 32'd0);
    checkOutput("rst_advance", 32'(advA), 32'd0);
    checkOutput("rst_forward_a", 32'(faA), 32'd0);
    checkOutput("rst_state", 32'(stA), 32'd0);
    checkOutput("rst_stall_cycles", 32'(scA), 32'd0);
    rst_n = 1'b1;
    memRegwrite = 1'b0; memRd = '0; exRs = '0;

    tick();
    checkOutput("run_pc_write", 32'(pcA), 32'd1);
    checkOutput("run_if_id_write", 32'(ifidA), 32'd1);
    checkOutput("run_bubble", 32'(bubA), 32'd0);

    // Forwarding priority, all within one cycle
    memRd = 5'd3; exRs = 5'd3; exRt = 5'd3; memRegwrite = 1'b1; wbRd = 5'd3; wbRegwrite = 1'b1;
    #1;
    checkOutput("fwd_a_exmem", 32'(faA), 32'd2);
    checkOutput("fwd_b_exmem", 32'(fbA), 32'd2);
    memRegwrite = 1'b0;
    #1;
    checkOutput("fwd_a_memwb", 32'(faA), 32'd1);
    memRd = '0; wbRd = '0; memRegwrite = 1'b1; exRs = '0; exRt = '0;
    #1;
    checkOutput("fwd_a_r0", 32'(faA), 32'd0);
    checkOutput("fwd_b_r0", 32'(fbA), 32'd0);
    exRs = 5'd3; exRt = 5'd4; memRd = 5'd4; wbRd = 5'd3;
    #1;
    checkOutput("fwd_a_split", 32'(faA), 32'd1);
    checkOutput("fwd_b_split", 32'(fbA), 32'd2);
    memRegwrite = 1'b0; wbRegwrite = 1'b0; memRd = '0; wbRd = '0; exRs = '0; exRt = '0;

    // rt only matters when the ID instruction reads it
    exMemread = 1'b1; exRd = 5'd6; idRt = 5'd6; idUsesRt = 1'b0;
    #1;
    checkOutput("luh_rt_unused", 32'(pcA), 32'd1);
    idUsesRt = 1'b1;
    #1;
    checkOutput("luh_rt_used", 32'(bubA), 32'd1);
    exRd = 5'd0; idRt = 5'd0;
    #1;
    checkOutput("luh_r0_ignored", 32'(pcA), 32'd1);
    exMemread = 1'b0; idUsesRt = 1'b0;

    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("luh_pc_write", 32'(pcA), 32'd0);
    checkOutput("luh_bubble", 32'(bubA), 32'd1);
    checkOutput("luh_advance", 32'(advA), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("l1_stall_cycles", 32'(scA), 32'd1);
    checkOutput("l1_state", 32'(stA), 32'd0);
    checkOutput("l1_bubble_done", 32'(bubA), 32'd0);
    checkOutput("l3_state_stall1", 32'(stB), 32'd1);
    checkOutput("l3_bubble2", 32'(bubB), 32'd1);
    tick();
    checkOutput("l3_state_stall2", 32'(stB), 32'd1);
    checkOutput("l3_bubble3", 32'(bubB), 32'd1);
    tick();
    checkOutput("l3_state_run", 32'(stB), 32'd0);
    checkOutput("l3_stall_cycles", 32'(scB), 32'd3);
    checkOutput("l3_pc_write", 32'(pcB), 32'd1);

    // Taken branch in the second STALL cycle aborts the stall
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("br_pre_state", 32'(stB), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("br_flush_d3", 32'(flB), 32'd7);
    checkOutput("br_flush_d1", 32'(flC), 32'd1);
    checkOutput("br_pc_write", 32'(pcB), 32'd1);
    checkOutput("br_bubble", 32'(bubB), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("br_state", 32'(stB), 32'd0);
    checkOutput("br_stall_cycles", 32'(scB), 32'd2);
    checkOutput("br_flush_events", 32'(feB), 32'd1);
    checkOutput("br_flush_clear", 32'(flB), 32'd0);

    // Freeze for 4 cycles during STALL, with a branch that must lose to the freeze
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("fz_pc_write", 32'(pcB), 32'd0);
    checkOutput("fz_if_id_write", 32'(ifidB), 32'd0);
    checkOutput("fz_advance", 32'(advB), 32'd0);
    checkOutput("fz_bubble", 32'(bubB), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("fz_state", 32'(stB), 32'd2);
    checkOutput("fz_branch_flush", 32'(flB), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("fz_branch_uncounted", 32'(feB), 32'd0);
    tick();
    checkOutput("fz_stall_held", 32'(scB), 32'd1);
    checkOutput("fz_state_a", 32'(stA), 32'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("fz_resume_bubble", 32'(bubB), 32'd1);
    checkOutput("fz_resume_pc", 32'(pcB), 32'd0);
    tick();
    checkOutput("fz_resume_state", 32'(stB), 32'd1);
    checkOutput("fz_resume_cnt", 32'(scB), 32'd2);
    checkOutput("fz_a_state_run", 32'(stA), 32'd0);
    tick();
    checkOutput("fz_done_state", 32'(stB), 32'd0);
    checkOutput("fz_done_cnt", 32'(scB), 32'd3);
    checkOutput("fz_a_cnt", 32'(scA), 32'd1);

    // Asynchronous reset in the middle of a stall
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_pre_state", 32'(stB), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_bubble", 32'(bubB), 32'd0);
    checkOutput("mid_rst_pc", 32'(pcB), 32'd0);
    checkOutput("mid_rst_state", 32'(stB), 32'd0);
    checkOutput("mid_rst_cnt", 32'(scB), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("mid_after_pc", 32'(pcB), 32'd1);

    // Continuous load-use for 20 cycles saturates the 4-bit counter
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("sat_cnt4", 32'(scC), 32'd15);
    checkOutput("sat_cnt16", 32'(scB), 32'd20);
    checkOutput("sat_bubble", 32'(bubC), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
